seg7_scan_drv: RTL and testbench

//  Display-side consumer of the watch's BCD digit outputs (hh:mm): latches four BCD digits

---
 rtl/seg7_scan_drv.sv | 133 +++++++++++++
 tb/tb_seg7_scan_drv.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_drv.sv
// Scans four latched BCD digits onto a shared 7-segment bus with guard blanking, colon drive and blink.
// Optional feature macro: LZ_BLANK_EN (blank the hours-tens digit when it is zero).
module seg7_scan_drv #(
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    input  logic       colon_i,
    input  logic       blink_en_i,
    input  logic [3:0] blink_mask_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       dp_o
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
    localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]       pre_cnt, pre_nxt;
    logic [1:0]          idx, idx_nxt;
    logic [FW-1:0]       frame_cnt, frame_nxt;
    logic                phase, phase_nxt;
    logic [3:0][3:0]     sh_dig;
    logic                sh_colon, sh_blink;
    logic [3:0]          sh_mask;
    logic                shadow_ld;
    logic [6:0]          seg_nxt;
    logic [3:0]          an_nxt;
    logic                dp_nxt;
    logic [3:0]          digit_cur;
    logic                blank;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    endfunction

    // State register, shadow latch and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
            sh_dig    <= '0;
            sh_colon  <= 1'b0;
            sh_blink  <= 1'b0;
            sh_mask   <= '0;
            seg_o     <= '0;
            an_o      <= '0;
            dp_o      <= 1'b0;
        end else begin
            pre_cnt   <= pre_nxt;
            idx       <= idx_nxt;
            frame_cnt <= frame_nxt;
            phase     <= phase_nxt;
            if (shadow_ld) begin
                sh_dig   <= {digit3_i, digit2_i, digit1_i, digit0_i};
                sh_colon <= colon_i;
                sh_blink <= blink_en_i;
                sh_mask  <= blink_mask_i;
            end
            seg_o <= seg_nxt;
            an_o  <= an_nxt;
            dp_o  <= dp_nxt;
        end
    end

    // Next-state: slot prescaler, digit index, frame counter and blink phase
    always_comb begin
        pre_nxt   = pre_cnt + 1'b1;
        idx_nxt   = idx;
        frame_nxt = frame_cnt;
        phase_nxt = phase;
        shadow_ld = (idx == 2'd0) && (pre_cnt == '0);
        if (pre_cnt == PRE_LAST) begin
            pre_nxt = '0;
            idx_nxt = idx + 2'd1;
            if (idx == 2'd3) begin
                if (frame_cnt == FR_LAST) begin
                    frame_nxt = '0;
                    phase_nxt = ~phase;
                end else begin
                    frame_nxt = frame_cnt + 1'b1;
                end
            end
        end
    end

    // Output decode; the slot's first GUARD cycles stay dark so the anode switch never ghosts
    always_comb begin
        seg_nxt   = '0;
        an_nxt    = '0;
        dp_nxt    = 1'b0;
        digit_cur = sh_dig[idx];
        blank     = sh_blink && sh_mask[idx] && phase;
        if (pre_cnt >= GUARD_END) begin
            an_nxt  = 4'b0001 << idx;
            seg_nxt = dec(digit_cur);
            dp_nxt  = (idx == 2'd2) && sh_colon;
`ifdef LZ_BLANK_EN
            if ((idx == 2'd3) && (digit_cur == 4'd0))
                seg_nxt = '0;
`else
`endif
            if (blank) begin
                seg_nxt = '0;
                dp_nxt  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2 (16-edge frames).
module tb_seg7_scan_drv;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] digit0_i, digit1_i, digit2_i, digit3_i;
    logic       colon_i, blink_en_i;
    logic [3:0] blink_mask_i;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    int n_cmp = 0;
    int n_err = 0;
    int kk    = 0;

    logic [6:0] seg_tab [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [3:0] an_tab  [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};

    seg7_scan_drv #(.SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .digit0_i(digit0_i), .digit1_i(digit1_i), .digit2_i(digit2_i), .digit3_i(digit3_i),
        .colon_i(colon_i), .blink_en_i(blink_en_i), .blink_mask_i(blink_mask_i),
        .seg_o(seg_o), .an_o(an_o), .dp_o(dp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        kk++;
    endtask

    task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
        digit3_i = d3; digit2_i = d2; digit1_i = d1; digit0_i = d0;
    endtask

    task automatic release_reset();
        rst_i = 1'b0;
        kk = -1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (seg_o !== 7'h00 || an_o !== 4'h0 || dp_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: seg=%h an=%h dp=%b, need 00/0/0", i, seg_o, an_o, dp_o);
            end
        end
    endtask

    task automatic test_scan(input int edges);
        logic [6:0] es;
        logic       ed;
        for (int i = 0; i < edges; i++) begin
            step();
            es = (kk % 4 == 0) ? 7'h00 : seg_tab[(kk / 4) % 4];
            ed = (kk % 4 != 0) && ((kk / 4) % 4 == 2);
            n_cmp++;
            if (an_o !== an_tab[kk % 16] || seg_o !== es || dp_o !== ed) begin
                n_err++;
                $display("FAIL scan edge%0d: an=%h seg=%h dp=%b, need %h/%h/%b",
                         kk, an_o, seg_o, dp_o, an_tab[kk % 16], es, ed);
            end
        end
    endtask

    task automatic test_tear();
        int fchg;
        for (int i = 0; i < 16 && (kk % 16) != 5; i++) step();
        digit1_i = 4'hA;
        fchg = kk / 16;
        for (int i = 0; i < 20; i++) begin
            step();
            if (an_tab[kk % 16] == 4'h2) begin
                n_cmp++;
                if (an_o !== 4'h2 || seg_o !== ((kk / 16 == fchg) ? 7'h4F : 7'h40)) begin
                    n_err++;
                    $display("FAIL tear edge%0d: an=%h seg=%h, need 2/%h", kk, an_o, seg_o,
                             (kk / 16 == fchg) ? 7'h4F : 7'h40);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] es;
        logic       ed, ph;
        int         s;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        blink_en_i = 1'b1;
        blink_mask_i = 4'b0011;
        rst_i = 1'b1;
        step();
        release_reset();
        for (int i = 0; i < 64; i++) begin
            step();
            s  = (kk / 4) % 4;
            ph = ((kk / 32) % 2) == 1;
            es = (kk % 4 == 0) ? 7'h00 : ((s < 2 && ph) ? 7'h00 : seg_tab[s]);
            ed = (kk % 4 != 0) && (s == 2);
            n_cmp++;
            if (an_o !== an_tab[kk % 16] || seg_o !== es || dp_o !== ed) begin
                n_err++;
                $display("FAIL blink edge%0d: an=%h seg=%h dp=%b, need %h/%h/%b",
                         kk, an_o, seg_o, dp_o, an_tab[kk % 16], es, ed);
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es;
`ifdef LZ_BLANK_EN
        es = 7'h00;
`else
        es = 7'h3F;
`endif
        blink_en_i = 1'b0;
        digit3_i = 4'd0;
        for (int i = 0; i < 16 && (kk % 16) != 15; i++) step();
        for (int i = 0; i < 16; i++) begin
            step();
            if ((kk % 16) >= 13) begin
                n_cmp++;
                if (an_o !== 4'h8 || seg_o !== es || dp_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL lz edge%0d: an=%h seg=%h dp=%b, need 8/%h/0", kk, an_o, seg_o, dp_o, es);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 16 && (kk % 16) != 10; i++) step();
        n_cmp++;
        if (an_o !== 4'h4) begin
            n_err++;
            $display("FAIL midrst_pre: an=%h, need 4", an_o);
        end
        rst_i = 1'b1;
        step();
        n_cmp++;
        if (seg_o !== 7'h00 || an_o !== 4'h0 || dp_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: seg=%h an=%h dp=%b, need 00/0/0", seg_o, an_o, dp_o);
        end
        release_reset();
        test_scan(20);
    endtask

    initial begin
        rst_i = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        colon_i = 1'b1;
        blink_en_i = 1'b0;
        blink_mask_i = 4'b0000;
        test_reset();
        release_reset();
        test_scan(32);
        test_tear();
        test_blink();
        test_lz();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
